wires_4x4b_to_5x3b_unpacker: RTL and testbench
==============================================

# wires_4x4b_to_5x3b_unpacker

Streaming width converter that undoes the 5x3b-to-4x4b packing. A frame of four 4-bit input words carries 15 payload bits plus one pad bit, and the block emits it as five 3-bit output words. The block buffers bits in a small shift register, handles the pad bit itself, and uses val/rdy handshakes on both sides. It sits downstream of a 4-bit link and feeds a 3-bit consumer.

## Interface
- No parameters. Widths are fixed by package constants.
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_val  input  1  in_msg is valid this cycle
- in_rdy  output  1  block can accept in_msg this cycle
- in_msg  input  4  input word; bit 0 is the oldest stream bit
- out_val  output  1  out_msg is valid this cycle
- out_rdy  input  1  consumer accepts out_msg this cycle
- out_msg  output  3  output word; bit 0 is the oldest stream bit
- out_last  output  1  high with out_val on the fifth (final) word of a frame

## Operation
- Stream order is LSB-first. Input word k of a frame supplies frame bits [4k+3:4k].
- Output word j of a frame carries frame bits [3j+2:3j].
- Frame bit 15 (in_msg[3] of the fourth word) is the pad bit. It is discarded and never enters the buffer.
- State:
  - buf: 7 bits
  - occ: 0..7, number of valid bits in buf
  - in_cnt: 0..3, input words accepted in the current frame
  - out_cnt: 0..4, output words emitted in the current frame
- Handshake signals:
  - in_rdy = (occ <= 3)
  - out_val = (occ >= 3)
  - out_msg = buf[2:0]
  - out_last = out_val && (out_cnt == 4)
  - in_rdy does not depend on out_rdy or in_val. out_val does not depend on in_val or out_rdy.
- A transfer fires when val and rdy are both high. in_fire and out_fire can occur in the same cycle only when occ == 3.
- Word size on input:
  - n = 3 when in_cnt == 3, otherwise n = 4.
  - Only in_msg[n-1:0] is enqueued.
- Next-state update, applied in this order:
  - If out_fire, shift buf right by 3 and reduce occ by 3.
  - If in_fire, place the enqueued bits at buf position occ (the post-dequeue occ) and increase occ by n.
  - in_cnt advances on in_fire and wraps 3 to 0.
  - out_cnt advances on out_fire and wraps 4 to 0.
- occ never exceeds 7, and occ is 0 at every frame boundary.
- Frames are back-to-back. There is no framing input.

## Timing
- Reset values: buf = 0, occ = 0, in_cnt = 0, out_cnt = 0. Outputs: in_rdy = 1, out_val = 0, out_msg = 0, out_last = 0.
- Latency: an output word becomes valid the cycle after the input fire that completes it. There is no combinational path from input to output.
- Throughput with in_val = 1 and out_rdy = 1 continuously, starting from reset:
  - in_fire at cycles 0, 2, 4, 6.
  - out_fire at cycles 1, 3, 5, 6, 7.
  - Cycle 7 also accepts word 0 of the next frame.
  - Steady state is one frame per 7 cycles.
- Back-pressure: with out_rdy = 0, out_val and out_msg hold stable, and in_rdy stays 0 once occ >= 4.
- in_val = 0 with out_rdy = 1: outputs drain until occ < 3, then out_val falls.
- Reset asserted mid-frame: partial frame contents are dropped, and the next accepted word is word 0 of a new frame.

## Structure
- A shared package holds:
  - IN_NBITS = 4, OUT_NBITS = 3
  - IN_WORDS = 4, OUT_WORDS = 5
  - BUF_NBITS = 7
  - PAD_BIT = 15
- The same package is used by the 5x3b-to-4x4b packer.
- The block is a single module with no sub-module. The buffer, occupancy and frame counters are flat registers.

## Test plan
- Reset: assert reset asynchronously -> in_rdy = 1, out_val = 0, out_last = 0 without waiting for a clock edge.
- Basic frame: inputs 0x1, 0xD, 0x8, 0x5 with out_rdy = 1 -> outputs 1, 2, 3, 4, 5; out_last only on 5.
- Second frame and pad bit: inputs 0x3, 0x6, 0xD, 0x7 -> outputs 3, 4, 5, 6, 7. Then inputs 0x1, 0xD, 0x8, 0xD (pad bit set) -> outputs 1, 2, 3, 4, 5.
- Throughput: two frames back-to-back with in_val = 1 and out_rdy = 1 -> fire pattern exactly as in Timing; second frame's out_last at cycle 14.
- Back-pressure: out_rdy = 0 for 5 cycles after the first input -> in_rdy = 0 and out_msg = 1 held stable. After release, the sequence continues 1, 2, 3, 4, 5 with no loss.
- Mid-frame reset: reset after two input words, then send 0x1, 0xD, 0x8, 0x5 -> outputs 1, 2, 3, 4, 5 with no stale bits.

Source files
------------

// File: rtl/wires_4x4b_to_5x3b_unpacker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wires_4x4b_to_5x3b_unpacker_pkg
//  Description : Shared constants, types and helpers for the 5x3b <-> 4x4b
//                packer/unpacker pair. A frame is 15 payload bits plus one
//                pad bit, seen as four 4-bit words or five 3-bit words.
//  Revision    : 1.0 - initial release
// ============================================================================
package wires_4x4b_to_5x3b_unpacker_pkg;

    // Link widths and frame geometry
    localparam int IN_NBITS  = 4;
    localparam int OUT_NBITS = 3;
    localparam int IN_WORDS  = 4;
    localparam int OUT_WORDS = 5;
    localparam int BUF_NBITS = 7;
    localparam int PAD_BIT   = 15;

    // Register widths for occupancy and frame position counters
    localparam int OCC_W     = 3;
    localparam int IN_CNT_W  = 2;
    localparam int OUT_CNT_W = 3;

    typedef logic [BUF_NBITS-1:0]  buf_t;
    typedef logic [OCC_W-1:0]      occ_t;
    typedef logic [IN_CNT_W-1:0]   in_cnt_t;
    typedef logic [OUT_CNT_W-1:0]  out_cnt_t;
    typedef logic [IN_NBITS-1:0]   in_word_t;
    typedef logic [OUT_NBITS-1:0]  out_word_t;

    // Payload bits carried by the final input word of a frame: everything
    // from its first bit up to, but not including, the pad bit.
    localparam int LAST_IN_NBITS = PAD_BIT - (IN_WORDS - 1) * IN_NBITS;

    // Occupancy thresholds and counter terminal values, pre-sized
    localparam occ_t     OCC_OUT_STEP  = occ_t'(OUT_NBITS);
    localparam occ_t     OCC_IN_LIMIT  = occ_t'(BUF_NBITS - IN_NBITS);
    localparam in_cnt_t  IN_CNT_LAST   = in_cnt_t'(IN_WORDS - 1);
    localparam out_cnt_t OUT_CNT_LAST  = out_cnt_t'(OUT_WORDS - 1);

    // Number of bits enqueued for the input word at frame position in_cnt
    function automatic occ_t word_nbits(input in_cnt_t in_cnt);
        occ_t n;
        if (in_cnt == IN_CNT_LAST) begin
            n = occ_t'(LAST_IN_NBITS);
        end else begin
            n = occ_t'(IN_NBITS);
        end
        return n;
    endfunction

    // Keep only the low n bits of an input word (drops the pad bit)
    function automatic in_word_t word_payload(input in_word_t w, input occ_t n);
        in_word_t m;
        for (int i = 0; i < IN_NBITS; i++) begin
            m[i] = (i < int'(n)) ? w[i] : 1'b0;
        end
        return m;
    endfunction

endpackage : wires_4x4b_to_5x3b_unpacker_pkg
`default_nettype wire

// File: rtl/wires_4x4b_to_5x3b_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : wires_4x4b_to_5x3b_unpacker
//  Description : Streaming 4-bit to 3-bit width converter. Each frame of four
//                4-bit words (15 payload bits + pad) is re-emitted as five
//                3-bit words through a 7-bit LSB-first shift buffer, with
//                val/rdy handshakes on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module wires_4x4b_to_5x3b_unpacker
    import wires_4x4b_to_5x3b_unpacker_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [IN_NBITS-1:0]  in_msg,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [OUT_NBITS-1:0] out_msg,
    output logic                 out_last
);

    buf_t     buf_q,     buf_d;
    occ_t     occ_q,     occ_d;
    in_cnt_t  in_cnt_q,  in_cnt_d;
    out_cnt_t out_cnt_q, out_cnt_d;

    logic     in_fire;
    logic     out_fire;
    buf_t     buf_after_deq;
    occ_t     occ_after_deq;
    occ_t     enq_nbits;
    in_word_t enq_bits;

    // Handshake outputs depend on registered state only, so there is no
    // combinational path from either input handshake to either output.
    always_comb begin
        in_rdy   = (occ_q <= OCC_IN_LIMIT);
        out_val  = (occ_q >= OCC_OUT_STEP);
        out_msg  = buf_q[OUT_NBITS-1:0];
        out_last = out_val && (out_cnt_q == OUT_CNT_LAST);
    end

    // Buffer update: dequeue first, then append the new word right above
    // the bits that remain. Bits above occ are always zero, so OR suffices.
    always_comb begin
        in_fire       = in_val && in_rdy;
        out_fire      = out_val && out_rdy;
        buf_after_deq = out_fire ? (buf_q >> OUT_NBITS) : buf_q;
        occ_after_deq = out_fire ? (occ_q - OCC_OUT_STEP) : occ_q;
        enq_nbits     = word_nbits(in_cnt_q);
        enq_bits      = word_payload(in_msg, enq_nbits);
        buf_d         = buf_after_deq;
        occ_d         = occ_after_deq;
        if (in_fire) begin
            buf_d = buf_after_deq | (buf_t'(enq_bits) << occ_after_deq);
            occ_d = occ_after_deq + enq_nbits;
        end
    end

    // Frame position counters: four input words and five output words
    always_comb begin
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (in_fire) begin
            in_cnt_d = (in_cnt_q == IN_CNT_LAST) ? '0 : in_cnt_q + in_cnt_t'(1);
        end
        if (out_fire) begin
            out_cnt_d = (out_cnt_q == OUT_CNT_LAST) ? '0 : out_cnt_q + out_cnt_t'(1);
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q     <= '0;
            occ_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            buf_q     <= buf_d;
            occ_q     <= occ_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule : wires_4x4b_to_5x3b_unpacker
`default_nettype wire

// File: tb/tb_wires_4x4b_to_5x3b_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wires_4x4b_to_5x3b_unpacker
//  Description : Self-checking bench for the 4x4b -> 5x3b unpacker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wires_4x4b_to_5x3b_unpacker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_val;
    logic       in_rdy;
    logic [3:0] in_msg;
    logic       out_val;
    logic       out_rdy;
    logic [2:0] out_msg;
    logic       out_last;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [3:0] tx_q[$];
    logic [2:0] obs_msg[$];
    logic       obs_last[$];
    int         in_cyc[$];
    int         out_cyc[$];
    int         last_cyc[$];

    wires_4x4b_to_5x3b_unpacker dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_msg   (in_msg),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_msg  (out_msg),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    // Frame-level reference: output word j is frame bits [3j+2:3j]
    function automatic logic [2:0] ref_word(input logic [3:0] w0, input logic [3:0] w1,
                                            input logic [3:0] w2, input logic [3:0] w3,
                                            input int j);
        logic [15:0] frame;
        frame = {w3, w2, w1, w0};
        return frame[3*j +: 3];
    endfunction

    task automatic clear_obs();
        obs_msg.delete();
        obs_last.delete();
        in_cyc.delete();
        out_cyc.delete();
        last_cyc.delete();
        tx_q.delete();
        cyc = 0;
    endtask

    task automatic reset_dut();
        in_val  = 1'b0;
        in_msg  = 4'h0;
        out_rdy = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_obs();
    endtask

    // One clock cycle of stimulus; called 1 time unit after a rising edge
    task automatic drive_cycle(input logic want, input logic rdy);
        logic f_in;
        logic f_out;
        in_val  = want && (tx_q.size() > 0);
        in_msg  = (tx_q.size() > 0) ? tx_q[0] : 4'h0;
        out_rdy = rdy;
        #1;
        f_in  = in_val && in_rdy;
        f_out = out_val && out_rdy;
        if (f_out) begin
            obs_msg.push_back(out_msg);
            obs_last.push_back(out_last);
            out_cyc.push_back(cyc);
            if (out_last) last_cyc.push_back(cyc);
        end
        if (f_in) begin
            void'(tx_q.pop_front());
            in_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until(input int want_outs, input int budget);
        int k;
        k = 0;
        while (obs_msg.size() < want_outs && k < budget) begin
            drive_cycle(1'b1, 1'b1);
            k++;
        end
        in_val = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++; if (in_rdy !== 1'b1)   $display("FAIL reset_in_rdy got %b want 1", in_rdy);   else n_pass++;
        n_checks++; if (out_val !== 1'b0)  $display("FAIL reset_out_val got %b want 0", out_val); else n_pass++;
        n_checks++; if (out_msg !== 3'd0)  $display("FAIL reset_out_msg got %0d want 0", out_msg); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else n_pass++;
        tx_q = '{4'h7};
        drive_cycle(1'b1, 1'b0);
        n_checks++; if (out_val !== 1'b1) $display("FAIL prereset_out_val got %b want 1", out_val); else n_pass++;
        // Assert reset between edges; outputs must clear without a clock
        #2 reset = 1'b1;
        #1;
        n_checks++; if (in_rdy !== 1'b1)   $display("FAIL async_reset_in_rdy got %b want 1", in_rdy);   else n_pass++;
        n_checks++; if (out_val !== 1'b0)  $display("FAIL async_reset_out_val got %b want 0", out_val); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL async_reset_out_last got %b want 0", out_last); else n_pass++;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [2:0] exp_w[5];
        exp_w = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        reset_dut();
        tx_q = '{4'h1, 4'hD, 4'h8, 4'h5};
        run_until(5, 40);
        n_checks++; if (obs_msg.size() != 5) $display("FAIL basic_count got %0d want 5", obs_msg.size()); else n_pass++;
        for (int i = 0; i < 5 && i < obs_msg.size(); i++) begin
            n_checks++; if (obs_msg[i] !== exp_w[i]) $display("FAIL basic_word%0d got %0d want %0d", i, obs_msg[i], exp_w[i]); else n_pass++;
            n_checks++; if (obs_last[i] !== (i == 4)) $display("FAIL basic_last%0d got %b want %b", i, obs_last[i], (i == 4)); else n_pass++;
        end
    endtask

    task automatic test_pad();
        logic [2:0] exp_w[10];
        exp_w = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        reset_dut();
        tx_q = '{4'h3, 4'h6, 4'hD, 4'h7, 4'h1, 4'hD, 4'h8, 4'hD};
        run_until(10, 60);
        n_checks++; if (obs_msg.size() != 10) $display("FAIL pad_count got %0d want 10", obs_msg.size()); else n_pass++;
        for (int i = 0; i < 10 && i < obs_msg.size(); i++) begin
            n_checks++; if (obs_msg[i] !== exp_w[i]) $display("FAIL pad_word%0d got %0d want %0d", i, obs_msg[i], exp_w[i]); else n_pass++;
            n_checks++; if (obs_last[i] !== (i % 5 == 4)) $display("FAIL pad_last%0d got %b want %b", i, obs_last[i], (i % 5 == 4)); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int exp_in[8];
        int exp_out[10];
        logic [3:0] w[8];
        exp_in  = '{0, 2, 4, 6, 7, 9, 11, 13};
        exp_out = '{1, 3, 5, 6, 7, 8, 10, 12, 13, 14};
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            w[i] = 4'($urandom_range(0, 15));
            tx_q.push_back(w[i]);
        end
        for (int k = 0; k < 16; k++) drive_cycle(1'b1, 1'b1);
        n_checks++; if (in_cyc.size() != 8)   $display("FAIL b2b_in_count got %0d want 8", in_cyc.size());    else n_pass++;
        n_checks++; if (out_cyc.size() != 10) $display("FAIL b2b_out_count got %0d want 10", out_cyc.size()); else n_pass++;
        for (int i = 0; i < 8 && i < in_cyc.size(); i++) begin
            n_checks++; if (in_cyc[i] != exp_in[i]) $display("FAIL b2b_in_cycle%0d got %0d want %0d", i, in_cyc[i], exp_in[i]); else n_pass++;
        end
        for (int i = 0; i < 10 && i < out_cyc.size(); i++) begin
            n_checks++; if (out_cyc[i] != exp_out[i]) $display("FAIL b2b_out_cycle%0d got %0d want %0d", i, out_cyc[i], exp_out[i]); else n_pass++;
            n_checks++;
            if (obs_msg[i] !== ref_word(w[4*(i/5)], w[4*(i/5)+1], w[4*(i/5)+2], w[4*(i/5)+3], i % 5))
                $display("FAIL b2b_word%0d got %0d want %0d", i, obs_msg[i],
                         ref_word(w[4*(i/5)], w[4*(i/5)+1], w[4*(i/5)+2], w[4*(i/5)+3], i % 5));
            else n_pass++;
        end
        n_checks++; if (last_cyc.size() != 2) $display("FAIL b2b_last_count got %0d want 2", last_cyc.size()); else n_pass++;
        if (last_cyc.size() == 2) begin
            n_checks++; if (last_cyc[0] != 7)  $display("FAIL b2b_last0_cycle got %0d want 7", last_cyc[0]);  else n_pass++;
            n_checks++; if (last_cyc[1] != 14) $display("FAIL b2b_last1_cycle got %0d want 14", last_cyc[1]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        tx_q = '{4'h1, 4'hD, 4'h8, 4'h5};
        drive_cycle(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (in_rdy !== 1'b0)  $display("FAIL bp_in_rdy%0d got %b want 0", k, in_rdy);   else n_pass++;
            n_checks++; if (out_val !== 1'b1) $display("FAIL bp_out_val%0d got %b want 1", k, out_val); else n_pass++;
            n_checks++; if (out_msg !== 3'd1) $display("FAIL bp_out_msg%0d got %0d want 1", k, out_msg); else n_pass++;
            drive_cycle(1'b1, 1'b0);
        end
        run_until(5, 40);
        n_checks++; if (obs_msg.size() != 5) $display("FAIL bp_count got %0d want 5", obs_msg.size()); else n_pass++;
        for (int i = 0; i < 5 && i < obs_msg.size(); i++) begin
            n_checks++; if (obs_msg[i] !== 3'(i + 1)) $display("FAIL bp_word%0d got %0d want %0d", i, obs_msg[i], i + 1); else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        tx_q = '{4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
        for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b1);
        n_checks++; if (in_cyc.size() != 2) $display("FAIL midrst_pre_inputs got %0d want 2", in_cyc.size()); else n_pass++;
        reset_dut();
        tx_q = '{4'h1, 4'hD, 4'h8, 4'h5};
        run_until(5, 40);
        n_checks++; if (obs_msg.size() != 5) $display("FAIL midrst_count got %0d want 5", obs_msg.size()); else n_pass++;
        for (int i = 0; i < 5 && i < obs_msg.size(); i++) begin
            n_checks++; if (obs_msg[i] !== 3'(i + 1)) $display("FAIL midrst_word%0d got %0d want %0d", i, obs_msg[i], i + 1); else n_pass++;
            n_checks++; if (obs_last[i] !== (i == 4)) $display("FAIL midrst_last%0d got %b want %b", i, obs_last[i], (i == 4)); else n_pass++;
        end
    endtask

    // Random traffic against a bit-queue model of the payload stream
    task automatic test_random();
        bit         bq[$];
        int         m_in;
        int         m_out;
        logic       v, r, e_rdy, e_val, e_last;
        logic [2:0] e_msg;
        logic [3:0] m;
        int         n;
        reset_dut();
        m_in  = 0;
        m_out = 0;
        for (int k = 0; k < 400; k++) begin
            e_rdy  = (bq.size() <= 3);
            e_val  = (bq.size() >= 3);
            e_last = e_val && (m_out == 4);
            e_msg  = e_val ? {bq[2], bq[1], bq[0]} : 3'd0;
            n_checks++; if (in_rdy !== e_rdy)   $display("FAIL rnd_in_rdy c%0d got %b want %b", k, in_rdy, e_rdy);     else n_pass++;
            n_checks++; if (out_val !== e_val)  $display("FAIL rnd_out_val c%0d got %b want %b", k, out_val, e_val);   else n_pass++;
            n_checks++; if (out_last !== e_last) $display("FAIL rnd_out_last c%0d got %b want %b", k, out_last, e_last); else n_pass++;
            if (e_val) begin
                n_checks++; if (out_msg !== e_msg) $display("FAIL rnd_out_msg c%0d got %0d want %0d", k, out_msg, e_msg); else n_pass++;
            end
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            m = 4'($urandom_range(0, 15));
            in_val  = v;
            in_msg  = m;
            out_rdy = r;
            @(posedge clk);
            #1;
            if (r && e_val) begin
                for (int b = 0; b < 3; b++) void'(bq.pop_front());
                m_out = (m_out + 1) % 5;
            end
            if (v && e_rdy) begin
                n = (m_in == 3) ? 3 : 4;
                for (int b = 0; b < n; b++) bq.push_back(m[b]);
                m_in = (m_in + 1) % 4;
            end
        end
        in_val  = 1'b0;
        out_rdy = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        in_val  = 1'b0;
        in_msg  = 4'h0;
        out_rdy = 1'b0;
        test_reset();
        test_basic();
        test_pad();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_wires_4x4b_to_5x3b_unpacker
`default_nettype wire
